serial_mag_compare_ctrl: RTL and testbench

//  Sequencer that resolves an N-bit unsigned magnitude comparison by streaming operand bits
//   MSB-first through one 1-bit compare cell, one bit per clock.

---
 rtl/cmp_pkg.sv | 20 ++
 rtl/bit_compare_cell.sv | 16 +
 rtl/serial_mag_compare_ctrl.sv | 136 +++++++++++++
 tb/tb_serial_mag_compare_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state
// encoding and the one-hot result codes driven onto gt/eq/lt.
package cmp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/bit_compare_cell.sv
// One-bit unsigned compare cell: c = a>b, d = a==b, e = a<b.
// Purely combinational; exactly one output is high for any input pair.
module bit_compare_cell (
  input  logic a,
  input  logic b,
  output logic c,
  output logic d,
  output logic e
);

  // Single-bit relations
  assign c = a & ~b;
  assign d = ~(a ^ b);
  assign e = ~a & b;

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Sequencer for an N-bit unsigned magnitude comparison that streams the
// operands MSB-first through a single 1-bit compare cell, one bit per clock.
//
// Handshake: start is sampled only in IDLE; an accepted start captures
// a_in/b_in and clears the result. busy is high in RUN and DONE, done pulses
// for the single DONE cycle, and gt/eq/lt (one-hot once valid, 000 while a
// compare is in flight or after reset) hold until the next accepted start.
// start while busy is dropped, not queued.
module serial_mag_compare_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [1:0]       fsm_state
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             sgt;
  logic             slt;
  logic             sgt_next;
  logic             slt_next;
  logic [2:0]       res;
  logic [2:0]       res_next;
  logic             cgt;
  logic             ceq;
  logic             clt;

  bit_compare_cell u_cell (
    .a (a_sh[WIDTH-1]),
    .b (b_sh[WIDTH-1]),
    .c (cgt),
    .d (ceq),
    .e (clt)
  );

  // Next state, sticky-flag update and result selection
  always_comb begin
    state_next = state;
    res_next   = res;
    sgt_next   = sgt;
    slt_next   = slt;
    // First difference wins: once either flag is set, later bits are ignored.
    if (!(sgt | slt)) begin
      sgt_next = cgt;
      slt_next = clt;
    end
    case (state)
      S_IDLE: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        // ~ceq marks a differing bit (same as cgt|clt for a one-hot cell).
        if (EARLY_EXIT && !ceq) begin
          res_next   = {cgt, 1'b0, clt};
          state_next = S_DONE;
        end else if (cnt == '0) begin
          res_next   = {sgt_next, ~(sgt_next | slt_next), slt_next};
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Operand capture, bit shifting, counter, sticky flags and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
      sgt  <= 1'b0;
      slt  <= 1'b0;
      res  <= RES_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh <= a_in;
            b_sh <= b_in;
            cnt  <= CNT_LAST;
            sgt  <= 1'b0;
            slt  <= 1'b0;
            res  <= RES_NONE;
          end
        end
        S_RUN: begin
          a_sh <= {a_sh[WIDTH-2:0], 1'b0};
          b_sh <= {b_sh[WIDTH-2:0], 1'b0};
          cnt  <= cnt - 1'b1;
          sgt  <= sgt_next;
          slt  <= slt_next;
          res  <= res_next;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign gt        = res[2];
  assign eq        = res[1];
  assign lt        = res[0];
  assign fsm_state = state;

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Bench for serial_mag_compare_ctrl at WIDTH=8. Two instances share clk/rst:
// index 0 has EARLY_EXIT=1, index 1 has EARLY_EXIT=0. Directed vectors with
// hand-computed results and latencies, then held-start back-to-back runs
// checked against a small reference model through an expected queue.
module tb_serial_mag_compare_ctrl;

  localparam logic [2:0] R_GT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;
  localparam logic [2:0] R_NO = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start_v = '0;
  logic [7:0] a_v [2];
  logic [7:0] b_v [2];
  logic [1:0] busy_v, done_v, gt_v, eq_v, lt_v;
  logic [1:0] st_v [2];

  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_ee (
    .clk(clk), .rst(rst), .start(start_v[0]), .a_in(a_v[0]), .b_in(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0]),
    .fsm_state(st_v[0])
  );

  serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst(rst), .start(start_v[1]), .a_in(a_v[1]), .b_in(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1]),
    .fsm_state(st_v[1])
  );

  function automatic logic [2:0] get_res(input int idx);
    return {gt_v[idx], eq_v[idx], lt_v[idx]};
  endfunction

  // Reference model: result code
  function automatic logic [2:0] model_res(input logic [7:0] a, input logic [7:0] b);
    if (a > b)      return R_GT;
    else if (a < b) return R_LT;
    else            return R_EQ;
  endfunction

  // Reference model: edges from accepted start to the edge entering DONE
  function automatic int model_lat(input logic [7:0] a, input logic [7:0] b, input bit ee);
    logic [7:0] x;
    x = a ^ b;
    if (!ee || x == 8'h00) return 8;
    for (int p = 7; p >= 0; p--) begin
      if (x[p]) return 8 - p;
    end
    return 8;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait for done on instance idx, counting edges; bounded
  task automatic wait_done(input int idx, output int k);
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end while (!done_v[idx] && k < 40);
    check("done_seen", 32'(done_v[idx]), 32'd1);
  endtask

  // Directed compare: drive start for one edge, check latency and result
  task automatic run_cmp(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] exp_res, input int exp_lat, input string tag);
    int k;
    @(negedge clk);
    a_v[idx] = a;
    b_v[idx] = b;
    start_v[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[idx] = 1'b0;
    a_v[idx] = ~a;
    b_v[idx] = ~b;
    check({tag, "_busy_run"}, 32'(busy_v[idx]), 32'd1);
    check({tag, "_res_run"}, 32'(get_res(idx)), 32'(R_NO));
    check({tag, "_done_early"}, 32'(done_v[idx]), 32'd0);
    wait_done(idx, k);
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_res"}, 32'(get_res(idx)), 32'(exp_res));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done_v[idx]), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy_v[idx]), 32'd0);
    check({tag, "_res_hold"}, 32'(get_res(idx)), 32'(exp_res));
  endtask

  initial begin
    int k;
    int n_done;
    int k_done;
    logic [2:0] r_done;
    logic [7:0] ca, cb;

    a_v[0] = '0; b_v[0] = '0; a_v[1] = '0; b_v[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", 32'(busy_v[i]), 32'd0);
      check("rst_done", 32'(done_v[i]), 32'd0);
      check("rst_res", 32'(get_res(i)), 32'(R_NO));
      check("rst_state", 32'(st_v[i]), 32'd0);
    end

    // 1: MSB differs, early exit
    run_cmp(0, 8'hA5, 8'h25, R_GT, 1, "t1_ee");
    // 2: equal operands, both modes
    run_cmp(0, 8'h3C, 8'h3C, R_EQ, 8, "t2_ee");
    run_cmp(1, 8'h3C, 8'h3C, R_EQ, 8, "t2_full");
    // 3: MSB wins over later bits
    run_cmp(1, 8'h80, 8'h7F, R_GT, 8, "t3_full");
    run_cmp(0, 8'h80, 8'h7F, R_GT, 1, "t3_ee");
    run_cmp(1, 8'h01, 8'h02, R_LT, 8, "t4_full");
    run_cmp(0, 8'h12, 8'h13, R_LT, 8, "lsb_ee");

    // 4: second start during RUN is ignored
    @(negedge clk);
    a_v[0] = 8'h01; b_v[0] = 8'h02; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    n_done = 0; k_done = 0; r_done = R_NO;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 3) begin start_v[0] = 1'b1; a_v[0] = 8'hFF; b_v[0] = 8'h00; end
      if (c == 4) start_v[0] = 1'b0;
      if (done_v[0]) begin
        n_done++;
        k_done = c;
        r_done = get_res(0);
      end
    end
    check("t4_done_count", 32'(n_done), 32'd1);
    check("t4_latency", 32'(k_done), 32'd7);
    check("t4_res", 32'(r_done), 32'(R_LT));
    check("t4_res_hold", 32'(get_res(0)), 32'(R_LT));
    check("t4_idle", 32'(busy_v[0]), 32'd0);

    // 5: reset in the 3rd RUN cycle
    @(negedge clk);
    a_v[1] = 8'h00; b_v[1] = 8'hFF; start_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("t5_busy_before", 32'(busy_v[1]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", 32'(busy_v[1]), 32'd0);
    check("t5_done", 32'(done_v[1]), 32'd0);
    check("t5_res", 32'(get_res(1)), 32'(R_NO));
    check("t5_state", 32'(st_v[1]), 32'd0);
    n_done = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[1]) n_done++;
    end
    check("t5_no_done", 32'(n_done), 32'd0);
    run_cmp(1, 8'hFF, 8'h00, R_GT, 8, "t5_after");

    // 6: start held high, random operands, both instances
    for (int idx = 0; idx < 2; idx++) begin
      @(negedge clk);
      ca = 8'($urandom_range(0, 255));
      cb = 8'($urandom_range(0, 255));
      a_v[idx] = ca; b_v[idx] = cb;
      start_v[idx] = 1'b1;
      for (int n = 0; n < 1000; n++) begin
        exp_q.push_back(model_res(ca, cb));
        @(posedge clk);
        wait_done(idx, k);
        check("t6_latency", 32'(k), 32'(model_lat(ca, cb, (idx == 0))));
        check("t6_res", 32'(get_res(idx)), 32'(exp_q.pop_front()));
        check("t6_onehot", 32'($countones(get_res(idx))), 32'd1);
        ca = 8'($urandom_range(0, 255));
        cb = ($urandom_range(0, 7) == 0) ? ca : 8'($urandom_range(0, 255));
        a_v[idx] = ca; b_v[idx] = cb;
        @(posedge clk);
        @(negedge clk);
        check("t6_idle_gap", 32'(busy_v[idx]), 32'd0);
      end
      start_v[idx] = 1'b0;
      repeat (12) @(posedge clk);
    end
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
